// File: rtl/hilo_sequencer.sv
// hilo_sequencer: decode-stage sequencer for the HI/LO instruction group.
// Decodes MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO, launches the shared
// multiply/divide unit, counts its latency and strobes the HI/LO write.
// Optional feature macro: HILO_RESTART_EN (a mul/div arriving while busy
// aborts the in-flight operation and restarts instead of stalling).
module hilo_sequencer #(
   parameter int MULT_CYCLES = 4,
   parameter int DIV_CYCLES  = 32,
   parameter int CNT_W       = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [5:0]       opcode,
   input  logic [5:0]       funct,
   input  logic             id_valid,
   input  logic             id_flush,
   output logic             start,
   output logic [1:0]       md_op,
   output logic             hilo_we,
   output logic             busy,
   output logic             stall_d,
   output logic             is_mf_hi,
   output logic             is_mf_lo,
   output logic             is_mt_hi,
   output logic             is_mt_lo,
   output logic [CNT_W-1:0] cycles_left
);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   localparam logic [5:0] F_MFHI = 6'h10;
   localparam logic [5:0] F_MTHI = 6'h11;
   localparam logic [5:0] F_MFLO = 6'h12;
   localparam logic [5:0] F_MTLO = 6'h13;

   localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
   localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   state_t           state;
   logic             special;
   logic             md_instr;
   logic             mfmt_op;
   logic             hilo_op;
   logic             md_issue;
   logic [CNT_W-1:0] load_val;

   // Decode the group, derive the stall and the mul/div issue condition.
   always_comb begin
      special  = (opcode == '0);
      is_mf_hi = id_valid && special && (funct == F_MFHI);
      is_mf_lo = id_valid && special && (funct == F_MFLO);
      is_mt_hi = id_valid && special && (funct == F_MTHI);
      is_mt_lo = id_valid && special && (funct == F_MTLO);
      // 0x18..0x1B share the upper funct bits 0110
      md_instr = id_valid && special && (funct[5:2] == 4'b0110);
      mfmt_op  = is_mf_hi || is_mf_lo || is_mt_hi || is_mt_lo;
      hilo_op  = mfmt_op || md_instr;
      busy     = (state == BUSY);
      hilo_we  = busy && (cycles_left == CNT_ONE);
`ifdef HILO_RESTART_EN
      stall_d  = mfmt_op && busy && !id_flush;
`else
      stall_d  = hilo_op && busy && !id_flush;
`endif
      md_issue = md_instr && id_valid && !id_flush && !stall_d;
      load_val = funct[1] ? DIV_LOAD : MULT_LOAD;
   end

   // Sequencer FSM: launch, latency countdown and return to idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         cycles_left <= '0;
         md_op       <= '0;
         start       <= 1'b0;
      end else begin
         start <= 1'b0;
         case (state)
            IDLE: begin
               if (md_issue) begin
                  state       <= BUSY;
                  md_op       <= funct[1:0];
                  cycles_left <= load_val;
                  start       <= 1'b1;
               end
            end
            BUSY: begin
`ifdef HILO_RESTART_EN
               // A restart wins over completion; the completion cycle's
               // hilo_we is combinational and still fires for the old result.
               if (md_issue) begin
                  md_op       <= funct[1:0];
                  cycles_left <= load_val;
                  start       <= 1'b1;
               end else
`endif
               if (cycles_left == CNT_ONE) begin
                  state       <= IDLE;
                  cycles_left <= '0;
               end else begin
                  cycles_left <= cycles_left - CNT_ONE;
               end
            end
            default: begin
               state       <= IDLE;
               cycles_left <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hilo_sequencer.sv
// tb_hilo_sequencer: directed, table-driven checks of hilo_sequencer with
// default latencies (u0) and with MULT_CYCLES=1 (u1).
module tb_hilo_sequencer;

   localparam logic [5:0] F_MFHI  = 6'h10;
   localparam logic [5:0] F_MTHI  = 6'h11;
   localparam logic [5:0] F_MFLO  = 6'h12;
   localparam logic [5:0] F_MTLO  = 6'h13;
   localparam logic [5:0] F_MULT  = 6'h18;
   localparam logic [5:0] F_MULTU = 6'h19;
   localparam logic [5:0] F_DIV   = 6'h1A;
   localparam logic [5:0] F_DIVU  = 6'h1B;

   logic       clk, rst_n;
   logic [5:0] opcode, funct;
   logic       id_valid, id_flush;

   logic       start0, hilo_we0, busy0, stall0, mfhi0, mflo0, mthi0, mtlo0;
   logic [1:0] md_op0;
   logic [5:0] left0;
   logic       start1, hilo_we1, busy1, stall1, mfhi1, mflo1, mthi1, mtlo1;
   logic [1:0] md_op1;
   logic [5:0] left1;

   int passed = 0;
   int total  = 0;
   int wcount;

   hilo_sequencer #(.MULT_CYCLES(4), .DIV_CYCLES(32), .CNT_W(6)) u0 (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
      .id_valid(id_valid), .id_flush(id_flush), .start(start0),
      .md_op(md_op0), .hilo_we(hilo_we0), .busy(busy0), .stall_d(stall0),
      .is_mf_hi(mfhi0), .is_mf_lo(mflo0), .is_mt_hi(mthi0),
      .is_mt_lo(mtlo0), .cycles_left(left0));

   hilo_sequencer #(.MULT_CYCLES(1), .DIV_CYCLES(32), .CNT_W(6)) u1 (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
      .id_valid(id_valid), .id_flush(id_flush), .start(start1),
      .md_op(md_op1), .hilo_we(hilo_we1), .busy(busy1), .stall_d(stall1),
      .is_mf_hi(mfhi1), .is_mf_lo(mflo1), .is_mt_hi(mthi1),
      .is_mt_lo(mtlo1), .cycles_left(left1));

   always #5 clk = ~clk;

   typedef struct {
      logic [5:0] op;
      logic [5:0] fn;
      logic       v;
      logic       f;
      logic [3:0] flags;   // {mf_hi, mf_lo, mt_hi, mt_lo}
      logic       busy_next;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   task automatic drive(input logic [5:0] op, input logic [5:0] fn,
                        input logic v, input logic f);
      opcode   = op;
      funct    = fn;
      id_valid = v;
      id_flush = f;
   endtask

   task automatic idle();
      drive(6'h00, 6'h00, 1'b0, 1'b0);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      clk = 1'b0;
      rst_n = 1'b0;
      idle();

      vecs[0] = '{6'h00, F_MFHI, 1'b1, 1'b0, 4'b1000, 1'b0};
      vecs[1] = '{6'h00, F_MFLO, 1'b1, 1'b0, 4'b0100, 1'b0};
      vecs[2] = '{6'h00, F_MTHI, 1'b1, 1'b0, 4'b0010, 1'b0};
      vecs[3] = '{6'h00, F_MTLO, 1'b1, 1'b0, 4'b0001, 1'b0};
      vecs[4] = '{6'h00, F_MFHI, 1'b0, 1'b0, 4'b0000, 1'b0};
      vecs[5] = '{6'h08, F_MFHI, 1'b1, 1'b0, 4'b0000, 1'b0};
      vecs[6] = '{6'h00, F_MULT, 1'b1, 1'b1, 4'b0000, 1'b0};
      vecs[7] = '{6'h00, F_DIV,  1'b0, 1'b0, 4'b0000, 1'b0};
      vecs[8] = '{6'h00, F_MTLO, 1'b1, 1'b1, 4'b0001, 1'b0};
      vecs[9] = '{6'h23, F_MULT, 1'b1, 1'b0, 4'b0000, 1'b0};

      // Reset state
      #2;
      chk("rst_busy",  busy0,    0);
      chk("rst_start", start0,   0);
      chk("rst_we",    hilo_we0, 0);
      chk("rst_stall", stall0,   0);
      chk("rst_left",  left0,    0);
      chk("rst_mdop",  md_op0,   0);
      step();
      step();
      rst_n = 1'b1;

      // Decode table in IDLE
      for (int i = 0; i < 10; i++) begin
         drive(vecs[i].op, vecs[i].fn, vecs[i].v, vecs[i].f);
         #1;
         chk($sformatf("vec%0d_flags", i), {mfhi0, mflo0, mthi0, mtlo0}, vecs[i].flags);
         chk($sformatf("vec%0d_stall", i), stall0, 0);
         step();
         chk($sformatf("vec%0d_busy", i), busy0, vecs[i].busy_next);
      end
      idle();
      step();

      // MULT then MFHI
      drive(6'h00, F_MULT, 1'b1, 1'b0);
      #1;
      chk("mult_idle_stall", stall0, 0);
      step();
      drive(6'h00, F_MFHI, 1'b1, 1'b0);
      #1;
      chk("mult_busy", busy0, 1);
      chk("mult_mdop", md_op0, 0);
      for (int k = 1; k <= 4; k++) begin
         chk($sformatf("mult_left_k%0d", k), left0, 5 - k);
         chk($sformatf("mult_stall_k%0d", k), stall0, 1);
         chk($sformatf("mult_we_k%0d", k), hilo_we0, (k == 4) ? 1 : 0);
         chk($sformatf("mult_start_k%0d", k), start0, (k == 1) ? 1 : 0);
         step();
      end
      chk("mult_done_busy", busy0, 0);
      chk("mfhi_nostall", stall0, 0);
      chk("mult_done_left", left0, 0);
      step();
      chk("mfhi_issue_busy", busy0, 0);
      idle();
      step();

      // DIV latency, with a flushed MFLO during BUSY
      drive(6'h00, F_DIV, 1'b1, 1'b0);
      #1;
      step();
      wcount = 0;
      for (int k = 1; k <= 32; k++) begin
         if (k == 5) drive(6'h00, F_MFLO, 1'b1, 1'b1);
         else idle();
         #1;
         if (k == 5) chk("flush_stall", stall0, 0);
         chk($sformatf("div_left_k%0d", k), left0, 33 - k);
         chk($sformatf("div_mdop_k%0d", k), md_op0, 2);
         chk($sformatf("div_we_k%0d", k), hilo_we0, (k == 32) ? 1 : 0);
         if (hilo_we0) wcount++;
         step();
      end
      chk("div_done_busy", busy0, 0);
      chk("div_we_count", wcount, 1);
      step();

      // Reset mid-DIV
      drive(6'h00, F_DIV, 1'b1, 1'b0);
      #1;
      step();
      drive(6'h00, F_MFHI, 1'b1, 1'b0);
      repeat (9) step();
      rst_n = 1'b0;
      #1;
      chk("mrst_busy",  busy0,    0);
      chk("mrst_we",    hilo_we0, 0);
      chk("mrst_stall", stall0,   0);
      chk("mrst_left",  left0,    0);
      chk("mrst_mdop",  md_op0,   0);
      chk("mrst_start", start0,   0);
      step();
      rst_n = 1'b1;
      idle();
      wcount = 0;
      for (int k = 0; k < 40; k++) begin
         step();
         if (hilo_we0) wcount++;
      end
      chk("mrst_no_we", wcount, 0);
      chk("mrst_idle", busy0, 0);

      // Back-to-back MULTU then DIVU
      drive(6'h00, F_MULTU, 1'b1, 1'b0);
      #1;
      step();
      drive(6'h00, F_DIVU, 1'b1, 1'b0);
      #1;
`ifdef HILO_RESTART_EN
      chk("b2b_restart_nostall", stall0, 0);
      chk("b2b_restart_we", hilo_we0, 0);
      step();
`else
      for (int k = 1; k <= 4; k++) begin
         chk($sformatf("b2b_stall_k%0d", k), stall0, 1);
         chk($sformatf("b2b_we_k%0d", k), hilo_we0, (k == 4) ? 1 : 0);
         step();
      end
      chk("b2b_free_stall", stall0, 0);
      chk("b2b_free_busy", busy0, 0);
      step();
`endif
      idle();
      #1;
      chk("b2b_start", start0, 1);
      chk("b2b_mdop", md_op0, 3);
      chk("b2b_left", left0, 32);
      wcount = 0;
      for (int k = 1; k <= 32; k++) begin
         if (k == 32) chk("b2b_div_we", hilo_we0, 1);
         if (hilo_we0) wcount++;
         step();
      end
      chk("b2b_we_count", wcount, 1);
      chk("b2b_done", busy0, 0);

      // MULT_CYCLES=1 instance
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      drive(6'h00, F_MULT, 1'b1, 1'b0);
      #1;
      step();
      drive(6'h00, F_MFHI, 1'b1, 1'b0);
      #1;
      chk("l1_start", start1,   1);
      chk("l1_we",    hilo_we1, 1);
      chk("l1_busy",  busy1,    1);
      chk("l1_stall", stall1,   1);
      chk("l1_left",  left1,    1);
      step();
      chk("l1_after_busy",  busy1,    0);
      chk("l1_after_stall", stall1,   0);
      chk("l1_after_we",    hilo_we1, 0);
      chk("l1_after_start", start1,   0);
      step();
      chk("l1_mfhi_idle", busy1, 0);
      idle();
      step();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
